// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART command framer: command codes, FSM state
// encodings, frame header bytes and frame lengths.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    CMD_RF_WR   = 2'd0,
    CMD_RF_RD   = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  localparam logic [7:0] HDR_RF_WR   = 8'hAA;
  localparam logic [7:0] HDR_RF_RD   = 8'hBB;
  localparam logic [7:0] HDR_ALU_OP  = 8'hCC;
  localparam logic [7:0] HDR_ALU_NOP = 8'hDD;

  localparam logic [2:0] LEN_RF_WR   = 3'd3;
  localparam logic [2:0] LEN_RF_RD   = 3'd2;
  localparam logic [2:0] LEN_ALU_OP  = 3'd4;
  localparam logic [2:0] LEN_ALU_NOP = 3'd2;

  function automatic logic [7:0] frame_header(input cmd_type_e t);
    logic [7:0] h;
    case (t)
      CMD_RF_WR:  h = HDR_RF_WR;
      CMD_RF_RD:  h = HDR_RF_RD;
      CMD_ALU_OP: h = HDR_ALU_OP;
      default:    h = HDR_ALU_NOP;
    endcase
    return h;
  endfunction

  // Index of the final byte of a frame (length minus one).
  function automatic logic [1:0] frame_last_idx(input cmd_type_e t);
    logic [2:0] len;
    case (t)
      CMD_RF_WR:  len = LEN_RF_WR;
      CMD_RF_RD:  len = LEN_RF_RD;
      CMD_ALU_OP: len = LEN_ALU_OP;
      default:    len = LEN_ALU_NOP;
    endcase
    return 2'(len - 3'd1);
  endfunction

endpackage

// File: rtl/uart_cmd_framer.sv
// Serialises register-file / ALU commands into byte frames for a UART
// transmitter using a valid/ready handshake on both sides.
module uart_cmd_framer
  import uart_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_type,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data_a,
  input  logic [DATA_WIDTH-1:0] cmd_data_b,
  input  logic [3:0]            cmd_fun,
  output logic [DATA_WIDTH-1:0] byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic [7:0]            frames_sent
);

  logic                  state;
  logic [1:0]            byte_idx;
  cmd_type_e             type_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_a_q;
  logic [DATA_WIDTH-1:0] data_b_q;
  logic [3:0]            fun_q;
  logic [DATA_WIDTH-1:0] byte_data_q;
  logic                  byte_valid_q;
  logic [7:0]            frames_q;

  logic [1:0]            next_idx;
  logic [DATA_WIDTH-1:0] next_byte;
  logic                  last_byte;
  logic                  byte_hs;

  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = (state == ST_SEND);
  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign frames_sent = frames_q;

  assign byte_hs   = byte_valid_q & byte_ready;
  assign next_idx  = byte_idx + 2'd1;
  assign last_byte = (byte_idx == frame_last_idx(type_q));

  // Payload byte that follows the current one, chosen from the captured fields.
  always_comb begin
    next_byte = '0;
    case (type_q)
      CMD_RF_WR: begin
        if (next_idx == 2'd1) next_byte = DATA_WIDTH'(addr_q);
        else if (next_idx == 2'd2) next_byte = data_a_q;
      end
      CMD_RF_RD: begin
        if (next_idx == 2'd1) next_byte = DATA_WIDTH'(addr_q);
      end
      CMD_ALU_OP: begin
        if (next_idx == 2'd1) next_byte = data_a_q;
        else if (next_idx == 2'd2) next_byte = data_b_q;
        else if (next_idx == 2'd3) next_byte = DATA_WIDTH'(fun_q);
      end
      default: begin
        if (next_idx == 2'd1) next_byte = DATA_WIDTH'(fun_q);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      byte_idx     <= 2'd0;
      type_q       <= CMD_RF_WR;
      addr_q       <= '0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      fun_q        <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frames_q     <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            type_q       <= cmd_type_e'(cmd_type);
            addr_q       <= cmd_addr;
            data_a_q     <= cmd_data_a;
            data_b_q     <= cmd_data_b;
            fun_q        <= cmd_fun;
            byte_idx     <= 2'd0;
            // Header is known straight from the command, so it leaves next cycle.
            byte_data_q  <= DATA_WIDTH'(frame_header(cmd_type_e'(cmd_type)));
            byte_valid_q <= 1'b1;
            state        <= ST_SEND;
          end
        end
        default: begin
          if (byte_hs) begin
            if (last_byte) begin
              byte_valid_q <= 1'b0;
              byte_idx     <= 2'd0;
              frames_q     <= frames_q + 8'd1;
              state        <= ST_IDLE;
            end else begin
              byte_idx    <= next_idx;
              byte_data_q <= next_byte;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: a table of single frames plus
// hand-written sequences for stalls, back-to-back commands, wrap and reset.
module tb_uart_cmd_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data_a;
  logic [7:0] cmd_data_b;
  logic [3:0] cmd_fun;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic [7:0] frames_sent;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_frames = 8'd0;

  typedef struct packed {
    logic [1:0]      ctype;
    logic [3:0]      addr;
    logic [7:0]      a;
    logic [7:0]      b;
    logic [3:0]      fun;
    logic [2:0]      len;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs [6];

  uart_cmd_framer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_type   (cmd_type),
    .cmd_addr   (cmd_addr),
    .cmd_data_a (cmd_data_a),
    .cmd_data_b (cmd_data_b),
    .cmd_fun    (cmd_fun),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] t, input logic [3:0] addr,
                                input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
    cmd_type   = t;
    cmd_addr   = addr;
    cmd_data_a = a;
    cmd_data_b = b;
    cmd_fun    = fun;
  endtask

  // One frame with byte_ready held high: bytes must come out back to back.
  task automatic run_frame(input vec_t v, input string tag);
    check_output({tag, "_cmd_ready_idle"}, cmd_ready, 1);
    apply_stimulus(v.ctype, v.addr, v.a, v.b, v.fun);
    cmd_valid  = 1'b1;
    byte_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output({tag, "_busy"}, busy, 1);
    check_output({tag, "_cmd_ready_send"}, cmd_ready, 0);
    for (int i = 0; i < int'(v.len); i++) begin
      check_output({tag, "_valid"}, byte_valid, 1);
      check_output({tag, "_byte"}, byte_data, v.exp[i]);
      @(negedge clk);
    end
    exp_frames = exp_frames + 8'd1;
    check_output({tag, "_valid_end"}, byte_valid, 0);
    check_output({tag, "_busy_end"}, busy, 0);
    check_output({tag, "_frames"}, frames_sent, exp_frames);
  endtask

  initial begin
    vecs[0] = '{2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 3'd3, {8'h00, 8'h3C, 8'h05, 8'hAA}};
    vecs[1] = '{2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 3'd2, {8'h00, 8'h00, 8'h0F, 8'hBB}};
    vecs[2] = '{2'd2, 4'h0, 8'h12, 8'h34, 4'h2, 3'd4, {8'h02, 8'h34, 8'h12, 8'hCC}};
    vecs[3] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'h8, 3'd2, {8'h00, 8'h00, 8'h08, 8'hDD}};
    vecs[4] = '{2'd0, 4'h0, 8'hFF, 8'h00, 4'h0, 3'd3, {8'h00, 8'hFF, 8'h00, 8'hAA}};
    vecs[5] = '{2'd2, 4'h9, 8'hFF, 8'h00, 4'hF, 3'd4, {8'h0F, 8'h00, 8'hFF, 8'hCC}};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    byte_ready = 1'b0;
    apply_stimulus(2'd0, 4'h0, 8'h00, 8'h00, 4'h0);
    #1;
    check_output("rst_valid", byte_valid, 0);
    check_output("rst_data", byte_data, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_frames", frames_sent, 0);
    @(negedge clk);
    rst_n = 1'b1;
    byte_ready = 1'b1;
    @(negedge clk);
    check_output("idle_ready", cmd_ready, 1);
    check_output("idle_ready_no_effect", byte_valid, 0);
    check_output("idle_frames", frames_sent, 0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // ALU_OP with the transmitter stalling on byte 2.
    apply_stimulus(2'd2, 4'h0, 8'h12, 8'h34, 4'h2);
    cmd_valid = 1'b1;
    byte_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("stall_b0", byte_data, 8'hCC);
    @(negedge clk);
    check_output("stall_b1", byte_data, 8'h12);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_output("stall_b2_hold", byte_data, 8'h34);
      check_output("stall_valid", byte_valid, 1);
      check_output("stall_busy", busy, 1);
      byte_ready = 1'b0;
      @(negedge clk);
    end
    check_output("stall_b2_release", byte_data, 8'h34);
    byte_ready = 1'b1;
    @(negedge clk);
    check_output("stall_b3", byte_data, 8'h02);
    check_output("stall_busy_b3", busy, 1);
    @(negedge clk);
    exp_frames = exp_frames + 8'd1;
    check_output("stall_done_valid", byte_valid, 0);
    check_output("stall_frames", frames_sent, exp_frames);

    // Back-to-back RF_RD then ALU_NOP with cmd_valid held high.
    apply_stimulus(2'd1, 4'hF, 8'h00, 8'h00, 4'h0);
    cmd_valid = 1'b1;
    @(negedge clk);
    check_output("b2b_bb", byte_data, 8'hBB);
    check_output("b2b_ready_send", cmd_ready, 0);
    apply_stimulus(2'd3, 4'h0, 8'h00, 8'h00, 4'h8);
    @(negedge clk);
    check_output("b2b_0f", byte_data, 8'h0F);
    check_output("b2b_ready_send2", cmd_ready, 0);
    @(negedge clk);
    exp_frames = exp_frames + 8'd1;
    check_output("b2b_bubble_valid", byte_valid, 0);
    check_output("b2b_bubble_ready", cmd_ready, 1);
    check_output("b2b_frames1", frames_sent, exp_frames);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("b2b_dd", byte_data, 8'hDD);
    check_output("b2b_dd_valid", byte_valid, 1);
    @(negedge clk);
    check_output("b2b_08", byte_data, 8'h08);
    @(negedge clk);
    exp_frames = exp_frames + 8'd1;
    check_output("b2b_end_valid", byte_valid, 0);
    check_output("b2b_frames2", frames_sent, exp_frames);

    // Command inputs wiggling during SEND must not leak into the frame.
    apply_stimulus(2'd0, 4'h3, 8'h55, 8'h00, 4'h0);
    cmd_valid = 1'b1;
    @(negedge clk);
    check_output("chg_aa", byte_data, 8'hAA);
    check_output("chg_ready0", cmd_ready, 0);
    apply_stimulus(2'd2, 4'hA, 8'h99, 8'h77, 4'h6);
    @(negedge clk);
    check_output("chg_03", byte_data, 8'h03);
    check_output("chg_ready1", cmd_ready, 0);
    apply_stimulus(2'd1, 4'hC, 8'h11, 8'h22, 4'h1);
    @(negedge clk);
    check_output("chg_55", byte_data, 8'h55);
    check_output("chg_ready2", cmd_ready, 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    exp_frames = exp_frames + 8'd1;
    check_output("chg_end_valid", byte_valid, 0);
    check_output("chg_frames", frames_sent, exp_frames);

    // Reset in the middle of an ALU_OP frame.
    apply_stimulus(2'd2, 4'h0, 8'h12, 8'h34, 4'h2);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("mrst_b0", byte_data, 8'hCC);
    @(negedge clk);
    check_output("mrst_b1", byte_data, 8'h12);
    rst_n = 1'b0;
    #1;
    exp_frames = 8'd0;
    check_output("mrst_valid", byte_valid, 0);
    check_output("mrst_data", byte_data, 0);
    check_output("mrst_busy", busy, 0);
    check_output("mrst_frames", frames_sent, exp_frames);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("mrst_after_ready", cmd_ready, 1);
      check_output("mrst_after_valid", byte_valid, 0);
      check_output("mrst_after_busy", busy, 0);
    end

    // 256 frames bring the counter back round to zero.
    for (int n = 0; n < 256; n++) run_frame(vecs[1], "wrap");
    check_output("wrap_zero", frames_sent, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_framer.md
UART_CMD_FRAMER -- requirements
Module: uart_cmd_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of operand/data fields and output byte.
REQ-002 Parameter ADDR_WIDTH, default 4: width of register-file address field.
REQ-003 CLK  in  1  single clock; all logic rising-edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command request present.
REQ-006 cmd_ready  out  1  framer accepts a command this cycle.
REQ-007 cmd_type  in  2  0=RF_WR, 1=RF_RD, 2=ALU_OP, 3=ALU_NOP.
REQ-008 cmd_addr  in  ADDR_WIDTH  register-file address.
REQ-009 cmd_data_a  in  DATA_WIDTH  write data (RF_WR) / operand A (ALU_OP).
REQ-010 cmd_data_b  in  DATA_WIDTH  operand B (ALU_OP).
REQ-011 cmd_fun  in  4  ALU function code.
REQ-012 byte_data  out  DATA_WIDTH  frame byte toward UART transmitter.
REQ-013 byte_valid  out  1  byte_data valid.
REQ-014 byte_ready  in  1  transmitter consumes byte this cycle.
REQ-015 busy  out  1  frame in progress.
REQ-016 frames_sent  out  8  count of completed frames, wrapping.

Function
REQ-017 Command handshake = cmd_valid & cmd_ready; byte handshake = byte_valid & byte_ready.
REQ-018 FSM states IDLE, SEND; IDLE->SEND on command handshake; SEND->IDLE on handshake of last frame byte.
REQ-019 cmd_ready = 1 only in IDLE; cmd_type/addr/data_a/data_b/fun captured into registers at command handshake and ignored otherwise.
REQ-020 Frame formats: RF_WR = 0xAA, addr, data_a (3 bytes); RF_RD = 0xBB, addr (2); ALU_OP = 0xCC, data_a, data_b, fun (4); ALU_NOP = 0xDD, fun (2).
REQ-021 addr and fun bytes zero-extended to DATA_WIDTH in the MSBs.
REQ-022 Header byte presented with byte_valid = 1 in the cycle after command handshake (latency 1).
REQ-023 byte_data and byte_valid registered; byte_data held stable while byte_valid & !byte_ready.
REQ-024 On byte handshake of a non-last byte, next byte presented the following cycle; byte_valid stays 1 with no gap.
REQ-025 Byte index counter 0..3 selects current byte; cleared on entry to SEND.
REQ-026 On last-byte handshake: byte_valid = 0 next cycle, FSM to IDLE, cmd_ready = 1 next cycle (one-cycle bubble between frames).
REQ-027 frames_sent increments by 1 on last-byte handshake; 255 wraps to 0.
REQ-028 busy = 1 in SEND, 0 in IDLE.
REQ-029 byte_ready while byte_valid = 0 has no effect; cmd_valid in SEND has no effect.

Reset
REQ-030 RST low asynchronously forces: state IDLE, cmd_ready 1 after release (IDLE), byte_valid 0, byte_data 0, busy 0, frames_sent 0, byte index 0, captured fields 0.
REQ-031 Reset mid-frame discards the frame; no partial continuation after release.

Structure
REQ-032 Package uart_frame_pkg holds cmd_type enum, state enum, header constants 0xAA/0xBB/0xCC/0xDD and per-type frame-length constants.
REQ-033 Single module, no sub-modules; byte selection is an internal combinational mux feeding the output register.

Verification
REQ-034 RF_WR addr=5 data=0x3C, byte_ready held 1 -> bytes 0xAA,0x05,0x3C on consecutive cycles, header one cycle after accept, frames_sent=1.
REQ-035 ALU_OP A=0x12 B=0x34 fun=0x2, byte_ready low 3 cycles on byte 2 -> 0xCC,0x12,0x34 (held stable 3 cycles),0x02; busy high throughout.
REQ-036 Back-to-back RF_RD addr=0xF then ALU_NOP fun=0x8, cmd_valid held 1 -> 0xBB,0x0F, one idle cycle, 0xDD,0x08; second command accepted only after bubble.
REQ-037 Change cmd inputs during SEND -> emitted bytes unaffected; cmd_ready 0 throughout.
REQ-038 256 RF_RD frames -> frames_sent returns to 0.
REQ-039 Assert RST during byte 1 of ALU_OP -> byte_valid 0 immediately, frames_sent 0, cmd_ready 1 after release, no residual bytes.
